axi_lite_arbiter_rr: RTL and testbench
======================================

# axi_lite_arbiter_rr

Parametrised N-master to 1-slave AXI4-Lite arbiter with independent round-robin (or fixed-priority) arbitration on the read and write paths. Sits between the CPU-side masters (IFU, LSU, future DMA/debug) and the single memory/crossbar slave port. It holds AXI channel stability while a request is stalled, binds write data to the write-address grant, and allows one outstanding read and one outstanding write concurrently.

## Interface
- `NUM_MASTERS`, 2: number of master ports, 2..8.
- `RR_EN`, 1: 1 selects round-robin; 0 selects fixed priority, where the lowest index wins.
- `IDW`, `$clog2(NUM_MASTERS)`: grant index width. Derived; do not override.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `m[NUM_MASTERS]` `axi_lite_if.slave` array: master ports. Carries AR/R/AW/W(wdata, wmask)/B at the `axi_lite_if` widths.
- `s` `axi_lite_if.master`: slave port.

## Operation
- Read FSM states: RD_IDLE, RD_ADDR, RD_DATA.
  - RD_IDLE: the arbiter picks `gnt` from the masters with `arvalid` set. It drives `s.arvalid=1` and `s.araddr=m[gnt].araddr`, and sets `m[gnt].arready=s.arready`. If `s.arready` is high, go to RD_DATA; otherwise latch `rd_gnt` and go to RD_ADDR.
  - RD_ADDR: `rd_gnt` is frozen and AR is forwarded from `m[rd_gnt]` only. Go to RD_DATA on `s.arready`.
  - RD_DATA: `m[rd_gnt].rvalid=s.rvalid`, `s.rready=m[rd_gnt].rready`, and `rresp` is routed. Go to RD_IDLE on `s.rvalid && s.rready`.
- Write FSM states: WR_IDLE, WR_ADDR, WR_RESP. Per-transaction flags `aw_done` and `w_done`.
  - WR_IDLE: pick `gnt` from the masters with `awvalid` set. Forward AW and also W from `m[gnt]`.
  - Leaving WR_IDLE: if both AW and W handshake in that cycle, go to WR_RESP. Otherwise latch `wr_gnt`, set `aw_done`/`w_done` from the handshakes that completed, and go to WR_ADDR.
  - WR_ADDR: forward only the channels still pending, from `m[wr_gnt]`. Go to WR_RESP once both flags are set, including the cycle in which the last one completes.
  - WR_RESP: route B to `m[wr_gnt]`. Go to WR_IDLE on `s.bvalid && s.bready`.
- W from a non-granted master is never forwarded, and its `wready` stays 0. A W offered before its AW waits until that master wins AW.
- Round-robin:
  - Separate pointers `rd_ptr` and `wr_ptr`, each reset to 0.
  - Search order: `ptr, ptr+1, …`, wrapping modulo `NUM_MASTERS`.
  - On completion of the R or B handshake, the pointer becomes `gnt+1`, wrapping to 0 past `NUM_MASTERS-1`.
  - With `RR_EN=0` the pointers are ignored.
- Read and write paths are fully independent. A read and a write to the same or different masters may be in flight at the same time.
- Non-granted masters see `arready`, `rvalid`, `awready`, `wready` and `bvalid` all 0, and `rresp`/`bresp` as 0.
- `rdata` is broadcast to all masters.

## Timing
- Zero added latency: the AR/AW issue cycle equals the master's request cycle when the arbiter is idle.
- Response routing is combinational: `s.rvalid` to `m.rvalid` in the same cycle.
- Back-to-back requests: a new grant is possible in the cycle after R/B completes, because the FSM spends one cycle in IDLE. Throughput is one read per 2 cycles minimum.
- Stability:
  - Once `s.arvalid` or `s.awvalid` is asserted, the grant and address cannot change until the handshake.
  - `s.wdata` and `s.wmask` are held likewise, from `m[wr_gnt]`.
- Reset:
  - Both FSMs go to IDLE, pointers go to 0, and all flags clear.
  - While `reset` is high, every valid/ready output on both sides is forced to 0.
  - Reset mid-transaction abandons the transaction; the slave is reset by the same signal.
- A request that drops `arvalid` or `awvalid` before its handshake is a protocol violation. Add an assertion; the behaviour is undefined.

## Structure
- Package `axi_arb_pkg`: `rd_state_t` and `wr_state_t` enums, plus the `rr_next(ptr, req)` function.
- Sub-module `rr_picker` with parameters `N` and `RR_EN`. It is purely combinational, takes `req[N]` and `ptr`, and outputs `gnt_idx` and `gnt_valid`. It is instantiated twice (AR and AW).
- Interface-array fields are unpacked into local `logic` arrays via a `generate` loop before muxing.

## Test plan
- N=3, RR: masters 0, 1 and 2 all hold `arvalid` continuously. Required: grant order 0,1,2,0. Each master's `rdata` is returned only on its own `rvalid`.
- N=2, slave `arready` held low 3 cycles: `m0` requests at 0x1000. Required: `s.araddr` stays 0x1000 for all 3 cycles even though `m1` also requests at 0x2000. `m1` is served after `m0`'s R completes.
- Write, W before AW: `m1` asserts W (`wdata` 0xDEADBEEF, `wmask` 0xF) 2 cycles before its AW to 0x80. Required: `wready` stays 0 until the AW grant, the slave receives that data and mask, and `bvalid` goes only to `m1`.
- Concurrency: `m0` read at 0x10 and `m1` write at 0x20 issued in the same cycle. Required: both proceed in parallel, with no cross-routing of R or B.
- `RR_EN=0`, N=4: masters 1 and 3 request continuously. Required: master 1 wins every time.
- Reset asserted during RD_DATA with `s.rvalid` low. Required: all outputs are 0 during reset. The first request after reset is granted from pointer 0.

Source files
------------

// File: rtl/axi_lite_arbiter_rr_pkg.sv
// Shared types, bus widths and the round-robin search helper for the AXI4-Lite arbiter.
package axi_arb_pkg;
   localparam int AXI_AW      = 32;
   localparam int AXI_DW      = 32;
   localparam int AXI_SW      = AXI_DW / 8;
   localparam int MAX_MASTERS = 8;
   localparam int PTR_W       = 3;

   typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
   typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_RESP} wr_state_t;

   // Callers zero-pad req above their master count, so wrapping modulo 8 walks
   // the same order as wrapping modulo the real master count.
   function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0]       ptr,
                                               input logic [MAX_MASTERS-1:0] req);
      logic [PTR_W-1:0] idx;
      rr_next = ptr;
      for (int k = MAX_MASTERS - 1; k >= 0; k--) begin
         idx = ptr + PTR_W'(k);
         if (req[idx]) rr_next = idx;
      end
   endfunction
endpackage

// File: rtl/axi_lite_arbiter_rr_if.sv
// AXI4-Lite channel bundle; master drives requests, slave drives responses.
interface axi_lite_if;
   import axi_arb_pkg::*;

   logic [AXI_AW-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [AXI_DW-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;
   logic [AXI_AW-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [AXI_DW-1:0] wdata;
   logic [AXI_SW-1:0] wmask;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   modport master (output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
                   input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid);
   modport slave  (input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
                   output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid);
endinterface

// File: rtl/axi_lite_arbiter_rr_rr_picker.sv
// Combinational requester picker: round-robin from ptr_i, or lowest index when RR_EN is 0.
module rr_picker
   import axi_arb_pkg::*;
#(
   parameter  int N     = 2,
   parameter  bit RR_EN = 1'b1,
   localparam int IDW   = $clog2(N)
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic [IDW-1:0] gnt_idx_o,
   output logic           gnt_valid_o
);
   logic [MAX_MASTERS-1:0] req_pad;
   logic [PTR_W-1:0]       ptr_pad;
   logic [PTR_W-1:0]       pick;

   always_comb begin
      req_pad        = '0;
      req_pad[N-1:0] = req_i;
      ptr_pad        = RR_EN ? PTR_W'(ptr_i) : '0;
      pick           = rr_next(ptr_pad, req_pad);
   end

   assign gnt_idx_o   = IDW'(pick);
   assign gnt_valid_o = |req_i;
endmodule

// File: rtl/axi_lite_arbiter_rr.sv
// N-master to 1-slave AXI4-Lite arbiter with independent read and write grant FSMs,
// one outstanding read and one outstanding write.
module axi_lite_arbiter_rr
   import axi_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter bit RR_EN       = 1'b1,
   parameter int IDW         = $clog2(NUM_MASTERS)
) (
   input logic        clk,
   input logic        reset,
   axi_lite_if.slave  m [NUM_MASTERS],
   axi_lite_if.master s
);
   logic [NUM_MASTERS-1:0] arvalid, rready, awvalid, wvalid, bready;
   logic [AXI_AW-1:0]      araddr [NUM_MASTERS];
   logic [AXI_AW-1:0]      awaddr [NUM_MASTERS];
   logic [AXI_DW-1:0]      wdata  [NUM_MASTERS];
   logic [AXI_SW-1:0]      wmask  [NUM_MASTERS];

   rd_state_t      rd_state_q;
   wr_state_t      wr_state_q;
   logic [IDW-1:0] rd_gnt_q, rd_ptr_q, wr_gnt_q, wr_ptr_q;
   logic           aw_done_q, w_done_q;

   logic [IDW-1:0] ar_pick, aw_pick, rd_sel, wr_sel;
   logic           ar_pick_vld, aw_pick_vld;
   logic           ar_fwd, rd_data_ph, wr_idle_go, wr_addr_ph, aw_fwd, w_fwd, wr_resp_ph;
   logic           s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
   logic           ar_hs, r_hs, aw_hs, w_hs, b_hs;

   function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] g);
      return (g == IDW'(NUM_MASTERS - 1)) ? '0 : g + IDW'(1);
   endfunction

   rr_picker #(.N(NUM_MASTERS), .RR_EN(RR_EN)) u_ar_pick (
      .req_i(arvalid), .ptr_i(rd_ptr_q), .gnt_idx_o(ar_pick), .gnt_valid_o(ar_pick_vld)
   );
   rr_picker #(.N(NUM_MASTERS), .RR_EN(RR_EN)) u_aw_pick (
      .req_i(awvalid), .ptr_i(wr_ptr_q), .gnt_idx_o(aw_pick), .gnt_valid_o(aw_pick_vld)
   );

   // While idle the live pick steers the muxes; afterwards the frozen grant does.
   always_comb begin
      rd_sel     = (rd_state_q == RD_IDLE) ? ar_pick : rd_gnt_q;
      ar_fwd     = !reset && ((rd_state_q == RD_IDLE && ar_pick_vld) || rd_state_q == RD_ADDR);
      rd_data_ph = !reset && rd_state_q == RD_DATA;
      s_arvalid  = ar_fwd && arvalid[rd_sel];
      s_rready   = rd_data_ph && rready[rd_gnt_q];
      ar_hs      = s_arvalid && s.arready;
      r_hs       = s.rvalid && s_rready;

      wr_sel     = (wr_state_q == WR_IDLE) ? aw_pick : wr_gnt_q;
      wr_idle_go = !reset && wr_state_q == WR_IDLE && aw_pick_vld;
      wr_addr_ph = !reset && wr_state_q == WR_ADDR;
      wr_resp_ph = !reset && wr_state_q == WR_RESP;
      aw_fwd     = wr_idle_go || (wr_addr_ph && !aw_done_q);
      w_fwd      = wr_idle_go || (wr_addr_ph && !w_done_q);
      s_awvalid  = aw_fwd && awvalid[wr_sel];
      s_wvalid   = w_fwd && wvalid[wr_sel];
      s_bready   = wr_resp_ph && bready[wr_gnt_q];
      aw_hs      = s_awvalid && s.awready;
      w_hs       = s_wvalid && s.wready;
      b_hs       = s.bvalid && s_bready;
   end

   assign s.arvalid = s_arvalid;
   assign s.araddr  = araddr[rd_sel];
   assign s.rready  = s_rready;
   assign s.awvalid = s_awvalid;
   assign s.awaddr  = awaddr[wr_sel];
   assign s.wvalid  = s_wvalid;
   assign s.wdata   = wdata[wr_sel];
   assign s.wmask   = wmask[wr_sel];
   assign s.bready  = s_bready;

   for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_port
      assign arvalid[gi]    = m[gi].arvalid;
      assign araddr[gi]     = m[gi].araddr;
      assign rready[gi]     = m[gi].rready;
      assign awvalid[gi]    = m[gi].awvalid;
      assign awaddr[gi]     = m[gi].awaddr;
      assign wvalid[gi]     = m[gi].wvalid;
      assign wdata[gi]      = m[gi].wdata;
      assign wmask[gi]      = m[gi].wmask;
      assign bready[gi]     = m[gi].bready;

      assign m[gi].arready = ar_fwd && (rd_sel == IDW'(gi)) && s.arready;
      assign m[gi].rvalid  = rd_data_ph && (rd_gnt_q == IDW'(gi)) && s.rvalid;
      assign m[gi].rresp   = (rd_data_ph && rd_gnt_q == IDW'(gi)) ? s.rresp : 2'b00;
      assign m[gi].rdata   = s.rdata;
      assign m[gi].awready = aw_fwd && (wr_sel == IDW'(gi)) && s.awready;
      assign m[gi].wready  = w_fwd && (wr_sel == IDW'(gi)) && s.wready;
      assign m[gi].bvalid  = wr_resp_ph && (wr_gnt_q == IDW'(gi)) && s.bvalid;
      assign m[gi].bresp   = (wr_resp_ph && wr_gnt_q == IDW'(gi)) ? s.bresp : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_state_q <= RD_IDLE;
         rd_gnt_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         unique case (rd_state_q)
            RD_IDLE: if (ar_pick_vld) begin
               rd_gnt_q   <= ar_pick;
               rd_state_q <= ar_hs ? RD_DATA : RD_ADDR;
            end
            RD_ADDR: if (ar_hs) rd_state_q <= RD_DATA;
            RD_DATA: if (r_hs) begin
               rd_state_q <= RD_IDLE;
               rd_ptr_q   <= ptr_inc(rd_gnt_q);
            end
            default: rd_state_q <= RD_IDLE;
         endcase
      end
   end

   // Flags remember which of AW/W already went through while the other is still pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state_q <= WR_IDLE;
         wr_gnt_q   <= '0;
         wr_ptr_q   <= '0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         unique case (wr_state_q)
            WR_IDLE: if (aw_pick_vld) begin
               wr_gnt_q <= aw_pick;
               if (aw_hs && w_hs) begin
                  wr_state_q <= WR_RESP;
               end else begin
                  wr_state_q <= WR_ADDR;
                  aw_done_q  <= aw_hs;
                  w_done_q   <= w_hs;
               end
            end
            WR_ADDR: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               wr_state_q <= WR_RESP;
               aw_done_q  <= 1'b0;
               w_done_q   <= 1'b0;
            end else begin
               aw_done_q  <= aw_done_q || aw_hs;
               w_done_q   <= w_done_q || w_hs;
            end
            WR_RESP: if (b_hs) begin
               wr_state_q <= WR_IDLE;
               wr_ptr_q   <= ptr_inc(wr_gnt_q);
            end
            default: wr_state_q <= WR_IDLE;
         endcase
      end
   end

   // A granted master must keep its address valid until the slave accepts it.
   always_ff @(posedge clk) begin
      if (!reset && rd_state_q == RD_ADDR) assert (arvalid[rd_gnt_q]);
      if (!reset && wr_state_q == WR_ADDR && !aw_done_q) assert (awvalid[wr_gnt_q]);
   end
endmodule

// File: tb/tb_axi_lite_arbiter_rr.sv
// Directed bench: a 3-master round-robin arbiter and a 4-master fixed-priority arbiter.
module tb_axi_lite_arbiter_rr;
   import axi_arb_pkg::*;

   localparam int NA = 3;
   localparam int NB = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   axi_lite_if ma [NA] ();
   axi_lite_if sa ();
   axi_lite_if mb [NB] ();
   axi_lite_if sb ();

   logic [NA-1:0]     a_arvalid, a_awvalid, a_wvalid;
   logic [AXI_AW-1:0] a_araddr [NA];
   logic [AXI_AW-1:0] a_awaddr [NA];
   logic [AXI_DW-1:0] a_wdata  [NA];
   logic [AXI_SW-1:0] a_wmask  [NA];
   logic [NA-1:0]     a_arready, a_rvalid, a_awready, a_wready, a_bvalid;
   logic [1:0]        a_rresp  [NA];
   logic [1:0]        a_bresp  [NA];
   logic [AXI_DW-1:0] a_rdata  [NA];

   logic [NB-1:0]     b_arvalid, b_arready, b_rvalid;

   for (genvar gi = 0; gi < NA; gi++) begin : g_ma
      assign ma[gi].arvalid = a_arvalid[gi];
      assign ma[gi].araddr  = a_araddr[gi];
      assign ma[gi].rready  = 1'b1;
      assign ma[gi].awvalid = a_awvalid[gi];
      assign ma[gi].awaddr  = a_awaddr[gi];
      assign ma[gi].wvalid  = a_wvalid[gi];
      assign ma[gi].wdata   = a_wdata[gi];
      assign ma[gi].wmask   = a_wmask[gi];
      assign ma[gi].bready  = 1'b1;
      assign a_arready[gi]  = ma[gi].arready;
      assign a_rvalid[gi]   = ma[gi].rvalid;
      assign a_rresp[gi]    = ma[gi].rresp;
      assign a_rdata[gi]    = ma[gi].rdata;
      assign a_awready[gi]  = ma[gi].awready;
      assign a_wready[gi]   = ma[gi].wready;
      assign a_bvalid[gi]   = ma[gi].bvalid;
      assign a_bresp[gi]    = ma[gi].bresp;
   end

   for (genvar gi = 0; gi < NB; gi++) begin : g_mb
      assign mb[gi].arvalid = b_arvalid[gi];
      assign mb[gi].araddr  = 32'(gi) << 8;
      assign mb[gi].rready  = 1'b1;
      assign mb[gi].awvalid = 1'b0;
      assign mb[gi].awaddr  = '0;
      assign mb[gi].wvalid  = 1'b0;
      assign mb[gi].wdata   = '0;
      assign mb[gi].wmask   = '0;
      assign mb[gi].bready  = 1'b1;
      assign b_arready[gi]  = mb[gi].arready;
      assign b_rvalid[gi]   = mb[gi].rvalid;
   end

   axi_lite_arbiter_rr #(.NUM_MASTERS(NA), .RR_EN(1'b1)) u_dut_rr (
      .clk(clk), .reset(reset), .m(ma), .s(sa)
   );
   axi_lite_arbiter_rr #(.NUM_MASTERS(NB), .RR_EN(1'b0)) u_dut_fp (
      .clk(clk), .reset(reset), .m(mb), .s(sb)
   );

   int n_checks = 0;
   int n_errors = 0;
   int g;
   int rr_order [4] = '{0, 1, 2, 0};
   int wr_order [2] = '{2, 0};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      a_arvalid = '0; a_awvalid = '0; a_wvalid = '0; b_arvalid = '0;
      for (int i = 0; i < NA; i++) begin
         a_araddr[i] = '0; a_awaddr[i] = '0; a_wdata[i] = '0; a_wmask[i] = '0;
      end
      sa.arready = 0; sa.rvalid = 0; sa.rdata = '0; sa.rresp = '0;
      sa.awready = 0; sa.wready = 0; sa.bvalid = 0; sa.bresp = '0;
      sb.arready = 0; sb.rvalid = 0; sb.rdata = '0; sb.rresp = '0;
      sb.awready = 0; sb.wready = 0; sb.bvalid = 0; sb.bresp = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      @(negedge clk); #1;
      chk("rst_s_arvalid", sa.arvalid, 0);
      chk("rst_s_awvalid", sa.awvalid, 0);
      chk("rst_m_ready", {a_arready, a_awready, a_wready}, 0);

      // round-robin reads, all three masters requesting
      for (int t = 0; t < 4; t++) begin
         g = rr_order[t];
         @(negedge clk);
         a_arvalid = 3'b111; sa.arready = 1; sa.rvalid = 0;
         a_araddr[0] = 32'h100; a_araddr[1] = 32'h200; a_araddr[2] = 32'h300;
         #1;
         chk("rr_araddr", sa.araddr, 64'h100 * (g + 1));
         chk("rr_arready", a_arready, 64'h1 << g);
         @(negedge clk);
         sa.rvalid = 1; sa.rdata = 32'hA0 + 32'(g); sa.rresp = 2'b10;
         #1;
         chk("rr_rvalid", a_rvalid, 64'h1 << g);
         chk("rr_rdata", a_rdata[g], 64'hA0 + g);
         chk("rr_rresp", {a_rresp[2], a_rresp[1], a_rresp[0]}, 64'h2 << (2 * g));
         chk("rr_rready", sa.rready, 1);
         $display("txn rd rr m%0d", g);
      end

      // stalled AR: m0 at 0x1000 held while m1 waits at 0x2000
      @(negedge clk);
      a_arvalid = 3'b001; a_araddr[0] = 32'h1000; a_araddr[1] = 32'h2000;
      sa.arready = 0; sa.rvalid = 0; sa.rresp = 0;
      #1;
      chk("stall_araddr", sa.araddr, 32'h1000);
      chk("stall_arvalid", sa.arvalid, 1);
      chk("stall_arready", a_arready, 0);
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         a_arvalid = 3'b011;
         #1;
         chk("stall_hold_araddr", sa.araddr, 32'h1000);
         chk("stall_hold_arready", a_arready, 0);
      end
      @(negedge clk);
      sa.arready = 1;
      #1;
      chk("stall_accept_araddr", sa.araddr, 32'h1000);
      chk("stall_accept_arready", a_arready, 3'b001);
      @(negedge clk);
      a_arvalid = 3'b010; sa.rvalid = 1; sa.rdata = 32'h1111;
      #1;
      chk("stall_m0_rvalid", a_rvalid, 3'b001);
      chk("stall_m1_waits", a_arready, 0);
      $display("txn rd stall m0 0x1000");
      @(negedge clk);
      sa.rvalid = 0;
      #1;
      chk("stall_m1_araddr", sa.araddr, 32'h2000);
      chk("stall_m1_arready", a_arready, 3'b010);
      @(negedge clk);
      a_arvalid = '0; sa.rvalid = 1;
      #1;
      chk("stall_m1_rvalid", a_rvalid, 3'b010);
      $display("txn rd stall m1 0x2000");

      // W from m1 offered two cycles before its AW
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         sa.rvalid = 0; sa.arready = 0; sa.awready = 1; sa.wready = 1;
         a_wvalid = 3'b010; a_wdata[1] = 32'hDEADBEEF; a_wmask[1] = 4'hF;
         #1;
         chk("wfirst_wready", a_wready, 0);
         chk("wfirst_s_wvalid", sa.wvalid, 0);
      end
      @(negedge clk);
      a_awvalid = 3'b010; a_awaddr[1] = 32'h80;
      #1;
      chk("wfirst_awaddr", sa.awaddr, 32'h80);
      chk("wfirst_s_wvalid_go", sa.wvalid, 1);
      chk("wfirst_wdata", sa.wdata, 32'hDEADBEEF);
      chk("wfirst_wmask", sa.wmask, 4'hF);
      chk("wfirst_aw_w_ready", {a_awready, a_wready}, 6'b010_010);
      @(negedge clk);
      a_awvalid = '0; a_wvalid = '0; sa.bvalid = 1; sa.bresp = 2'b01;
      #1;
      chk("wfirst_bvalid", a_bvalid, 3'b010);
      chk("wfirst_bresp", {a_bresp[2], a_bresp[1], a_bresp[0]}, 6'b00_01_00);
      $display("txn wr m1 0x80");

      // concurrent read (m0) and write (m1), W accepted a cycle after AW
      @(negedge clk);
      sa.bvalid = 0; sa.bresp = 0;
      a_arvalid = 3'b001; a_araddr[0] = 32'h10;
      a_awvalid = 3'b010; a_awaddr[1] = 32'h20;
      a_wvalid = 3'b010; a_wdata[1] = 32'h12345678; a_wmask[1] = 4'h3;
      sa.arready = 1; sa.awready = 1; sa.wready = 0;
      #1;
      chk("cc_araddr", sa.araddr, 32'h10);
      chk("cc_awaddr", sa.awaddr, 32'h20);
      chk("cc_ready", {a_arready, a_awready, a_wready}, 9'b001_010_000);
      @(negedge clk);
      a_arvalid = '0; a_awvalid = '0; sa.wready = 1; sa.rvalid = 1; sa.rdata = 32'h55;
      #1;
      chk("cc_rvalid", a_rvalid, 3'b001);
      chk("cc_s_aw_w_valid", {sa.awvalid, sa.wvalid}, 2'b01);
      chk("cc_wdata", sa.wdata, 32'h12345678);
      chk("cc_wready", a_wready, 3'b010);
      chk("cc_no_bvalid", a_bvalid, 0);
      @(negedge clk);
      a_wvalid = '0; sa.rvalid = 0; sa.wready = 0; sa.bvalid = 1;
      #1;
      chk("cc_bvalid", a_bvalid, 3'b010);
      chk("cc_no_rvalid", a_rvalid, 0);
      $display("txn rd m0 0x10 with wr m1 0x20");

      // write round-robin: m0 and m2 compete, pointer sits at 2
      for (int t = 0; t < 2; t++) begin
         g = wr_order[t];
         @(negedge clk);
         sa.bvalid = 0; sa.awready = 1; sa.wready = 1;
         a_awvalid = 3'b101; a_wvalid = 3'b101;
         a_awaddr[0] = 32'h400; a_awaddr[2] = 32'h600;
         a_wdata[0] = 32'hA; a_wdata[2] = 32'hC;
         #1;
         chk("wrr_awaddr", sa.awaddr, (g == 0) ? 64'h400 : 64'h600);
         chk("wrr_wdata", sa.wdata, (g == 0) ? 64'hA : 64'hC);
         chk("wrr_wready", a_wready, 64'h1 << g);
         @(negedge clk);
         sa.bvalid = 1;
         #1;
         chk("wrr_bvalid", a_bvalid, 64'h1 << g);
         $display("txn wr rr m%0d", g);
      end

      // reset during RD_DATA with rvalid low
      @(negedge clk);
      a_awvalid = '0; a_wvalid = '0; sa.bvalid = 0;
      a_arvalid = 3'b100; a_araddr[2] = 32'h300; sa.arready = 1; sa.rvalid = 0;
      #1;
      chk("rst_pre_arready", a_arready, 3'b100);
      @(negedge clk);
      a_arvalid = 3'b011; a_araddr[0] = 32'h10; a_araddr[1] = 32'h20;
      #1;
      chk("rst_pre_rready", sa.rready, 1);
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         reset = 1; sa.awready = 1; sa.wready = 1; a_awvalid = 3'b001; a_wvalid = 3'b001;
         #1;
         chk("rst_s_outs", {sa.arvalid, sa.rready, sa.awvalid, sa.wvalid, sa.bready}, 0);
         chk("rst_m_outs", {a_arready, a_rvalid, a_awready, a_wready, a_bvalid}, 0);
      end
      @(negedge clk);
      reset = 0; a_awvalid = '0; a_wvalid = '0;
      #1;
      chk("rst_first_araddr", sa.araddr, 32'h10);
      chk("rst_first_arready", a_arready, 3'b001);
      @(negedge clk);
      a_arvalid = '0; sa.rvalid = 1;
      #1;
      chk("rst_first_rvalid", a_rvalid, 3'b001);
      $display("txn rd after reset m0");
      @(negedge clk);
      sa.rvalid = 0;

      // fixed priority: masters 1 and 3 request continuously
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         b_arvalid = 4'b1010; sb.arready = 1; sb.rvalid = 0;
         #1;
         chk("fp_araddr", sb.araddr, 32'h100);
         chk("fp_arready", b_arready, 4'b0010);
         @(negedge clk);
         sb.rvalid = 1;
         #1;
         chk("fp_rvalid", b_rvalid, 4'b0010);
         $display("txn rd fixed m1");
      end
      @(negedge clk);
      b_arvalid = '0; sb.rvalid = 0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
